// File: rtl/morse_decoder.sv
// Morse loopback decoder: times marks/spaces in dot units and rebuilds digit words.
// Define MORSE_DECODER_HEX_EN to also decode the letters A-F as values 10-15.
module morse_decoder #(
   parameter int DOT_CYCLES     = 2400000,
   parameter int PARALLEL_WIDTH = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      serial_i,
   output logic [3:0]                digit_o,
   output logic                      digit_valid_o,
   output logic [PARALLEL_WIDTH-1:0] parallel_o,
   output logic                      word_valid_o,
   output logic                      overflow_o,
   output logic                      error_o
);

   localparam int SUB_W  = $clog2(DOT_CYCLES);
   localparam int NDIG   = PARALLEL_WIDTH / 4;
   localparam int DCNT_W = $clog2(NDIG + 1);

   typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

   // Output semantics: no handshake; digit_valid_o, word_valid_o and error_o are
   // single-cycle pulses, digit_o / parallel_o / overflow_o hold until replaced.

   logic             s_meta, s, s_prev;
   logic             rise, fall, edge_s;
   logic [SUB_W-1:0] sub;
   logic [2:0]       units;
   logic             tick2, tick5;

   state_t                    state, next_state;
   logic [4:0]                pattern, next_pattern;
   logic [2:0]                elem_cnt, next_elem_cnt;
   logic                      letter_err, next_letter_err;
   logic [PARALLEL_WIDTH-1:0] acc, next_acc;
   logic [DCNT_W-1:0]         dig_cnt, next_dig_cnt;
   logic                      ovf, next_ovf;
   logic [3:0]                next_digit;
   logic                      next_digit_valid, next_word_valid, next_error;
   logic [PARALLEL_WIDTH-1:0] next_parallel;
   logic                      next_overflow;
   logic [4:0]                dec;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s_meta <= 1'b0;
         s      <= 1'b0;
         s_prev <= 1'b0;
      end else begin
         s_meta <= serial_i;
         s      <= s_meta;
         s_prev <= s;
      end
   end

   assign rise   = s & ~s_prev;
   assign fall   = ~s & s_prev;
   assign edge_s = s ^ s_prev;

   // The edge is seen one clk after s changed, so the sub-counter restarts at 1
   // to keep unit boundaries exactly n*DOT_CYCLES after the change of s.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sub   <= '0;
         units <= '0;
      end else if (edge_s) begin
         sub   <= SUB_W'(1);
         units <= '0;
      end else if (sub == SUB_W'(DOT_CYCLES - 1)) begin
         sub <= '0;
         if (units != 3'd7) units <= units + 3'd1;
      end else begin
         sub <= sub + SUB_W'(1);
      end
   end

   assign tick2 = (units == 3'd2) && (sub == '0);
   assign tick5 = (units == 3'd5) && (sub == '0);

   // Returns {valid, value}; the first-sent element sits in the highest used bit.
   function automatic logic [4:0] decode(input logic [2:0] n, input logic [4:0] p);
      logic [7:0] key;
      logic [4:0] r;
      key = {n, p};
      case (key)
         {3'd5, 5'b11111}: r = {1'b1, 4'd0};
         {3'd5, 5'b01111}: r = {1'b1, 4'd1};
         {3'd5, 5'b00111}: r = {1'b1, 4'd2};
         {3'd5, 5'b00011}: r = {1'b1, 4'd3};
         {3'd5, 5'b00001}: r = {1'b1, 4'd4};
         {3'd5, 5'b00000}: r = {1'b1, 4'd5};
         {3'd5, 5'b10000}: r = {1'b1, 4'd6};
         {3'd5, 5'b11000}: r = {1'b1, 4'd7};
         {3'd5, 5'b11100}: r = {1'b1, 4'd8};
         {3'd5, 5'b11110}: r = {1'b1, 4'd9};
`ifdef MORSE_DECODER_HEX_EN
         {3'd2, 5'b00001}: r = {1'b1, 4'd10};
         {3'd4, 5'b01000}: r = {1'b1, 4'd11};
         {3'd4, 5'b01010}: r = {1'b1, 4'd12};
         {3'd3, 5'b00100}: r = {1'b1, 4'd13};
         {3'd1, 5'b00000}: r = {1'b1, 4'd14};
         {3'd4, 5'b00010}: r = {1'b1, 4'd15};
`endif
         default:          r = 5'd0;
      endcase
      return r;
   endfunction

   assign dec = decode(elem_cnt, pattern);

   always_comb begin
      next_state       = state;
      next_pattern     = pattern;
      next_elem_cnt    = elem_cnt;
      next_letter_err  = letter_err;
      next_acc         = acc;
      next_dig_cnt     = dig_cnt;
      next_ovf         = ovf;
      next_digit       = digit_o;
      next_digit_valid = 1'b0;
      next_word_valid  = 1'b0;
      next_error       = 1'b0;
      next_parallel    = parallel_o;
      next_overflow    = overflow_o;
      case (state)
         IDLE: begin
            if (rise) next_state = MARK;
         end
         MARK: begin
            if (fall) begin
               next_state = SPACE;
               if (units >= 3'd5) begin
                  next_error      = 1'b1;
                  next_pattern    = '0;
                  next_elem_cnt   = '0;
                  next_letter_err = 1'b0;
               end else if (elem_cnt == 3'd5) begin
                  next_letter_err = 1'b1;
               end else begin
                  next_pattern  = {pattern[3:0], (units >= 3'd2)};
                  next_elem_cnt = elem_cnt + 3'd1;
               end
            end
         end
         SPACE: begin
            // The edge wins over a threshold landing in the same cycle.
            if (rise) begin
               next_state = MARK;
            end else if (tick2) begin
               if (elem_cnt != 3'd0) begin
                  if (letter_err || !dec[4]) begin
                     next_error = 1'b1;
                  end else begin
                     next_digit       = dec[3:0];
                     next_digit_valid = 1'b1;
                     next_acc         = {acc[PARALLEL_WIDTH-5:0], dec[3:0]};
                     if (dig_cnt == DCNT_W'(NDIG)) next_ovf = 1'b1;
                     else next_dig_cnt = dig_cnt + DCNT_W'(1);
                  end
               end
               next_pattern    = '0;
               next_elem_cnt   = '0;
               next_letter_err = 1'b0;
            end else if (tick5) begin
               if (dig_cnt != '0) begin
                  next_word_valid = 1'b1;
                  next_parallel   = acc;
                  next_overflow   = ovf;
               end
               next_acc     = '0;
               next_dig_cnt = '0;
               next_ovf     = 1'b0;
               next_state   = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state         <= IDLE;
         pattern       <= '0;
         elem_cnt      <= '0;
         letter_err    <= 1'b0;
         acc           <= '0;
         dig_cnt       <= '0;
         ovf           <= 1'b0;
         digit_o       <= '0;
         digit_valid_o <= 1'b0;
         word_valid_o  <= 1'b0;
         error_o       <= 1'b0;
         parallel_o    <= '0;
         overflow_o    <= 1'b0;
      end else begin
         state         <= next_state;
         pattern       <= next_pattern;
         elem_cnt      <= next_elem_cnt;
         letter_err    <= next_letter_err;
         acc           <= next_acc;
         dig_cnt       <= next_dig_cnt;
         ovf           <= next_ovf;
         digit_o       <= next_digit;
         digit_valid_o <= next_digit_valid;
         word_valid_o  <= next_word_valid;
         error_o       <= next_error;
         parallel_o    <= next_parallel;
         overflow_o    <= next_overflow;
      end
   end

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder with DOT_CYCLES=4: exact pulse timing, digit
// words, overflow, long-mark error, hex letters (MORSE_DECODER_HEX_EN) and reset.
module tb_morse_decoder;

   localparam int DOT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        serial = 1'b0;
   logic [3:0]  digit;
   logic        digit_valid;
   logic [15:0] parallel;
   logic        word_valid;
   logic        overflow;
   logic        error;

   int checks = 0;
   int errors = 0;

   logic [3:0]  dig_q[$];
   logic [15:0] par_q[$];
   logic        ovf_q[$];
   int          err_n = 0;
   int          d0, w0, e0;

   morse_decoder #(.DOT_CYCLES(DOT), .PARALLEL_WIDTH(16)) dut (
      .clk_i(clk), .rst_i(rst), .serial_i(serial),
      .digit_o(digit), .digit_valid_o(digit_valid),
      .parallel_o(parallel), .word_valid_o(word_valid),
      .overflow_o(overflow), .error_o(error)
   );

   always #5 clk = ~clk;

   // Pulse recorder, sampled away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (digit_valid) dig_q.push_back(digit);
         if (word_valid) begin
            par_q.push_back(parallel);
            ovf_q.push_back(overflow);
         end
         if (error) err_n++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic hold(input logic v, input int cycles);
      serial = v;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic string code_of(input int d);
      case (d)
         0: return "-----";
         1: return ".----";
         2: return "..---";
         3: return "...--";
         4: return "....-";
         5: return ".....";
         6: return "-....";
         7: return "--...";
         8: return "---..";
         default: return "----.";
      endcase
   endfunction

   // Sends the elements of one letter; leaves the line high after the last one.
   task automatic send_code(input string c);
      for (int i = 0; i < c.len(); i++) begin
         if (i != 0) hold(1'b0, DOT);
         hold(1'b1, (c[i] == 8'h2D) ? 3 * DOT : DOT);
      end
   endtask

   task automatic mark_start();
      d0 = dig_q.size();
      w0 = par_q.size();
      e0 = err_n;
   endtask

   task automatic chk_word(input string tag, input logic [15:0] p, input logic o);
      chk({tag, "_nword"}, par_q.size() - w0, 1);
      if (par_q.size() > w0) begin
         chk({tag, "_par"}, par_q[w0], p);
         chk({tag, "_ovf"}, ovf_q[w0], o);
      end
   endtask

   initial begin
      // Reset
      hold(1'b0, 3);
      chk("rst_digit", digit, 0);
      chk("rst_par", parallel, 0);
      chk("rst_flags", {digit_valid, word_valid, overflow, error}, 0);
      rst = 1'b0;
      hold(1'b0, 10);
      chk("idle_par", parallel, 0);
      chk("idle_flags", {digit_valid, word_valid, overflow, error}, 0);

      // "1" with exact pulse timing, then word gap
      mark_start();
      send_code(code_of(1));
      serial = 1'b0;
      repeat (11) @(negedge clk);
      chk("t1_dv_early", digit_valid, 0);
      @(negedge clk);
      chk("t1_dv", digit_valid, 1);
      chk("t1_digit", digit, 1);
      repeat (11) @(negedge clk);
      chk("t1_wv_early", word_valid, 0);
      @(negedge clk);
      chk("t1_wv", word_valid, 1);
      chk("t1_par", parallel, 16'h0001);
      chk("t1_ovf", overflow, 0);
      @(posedge clk);
      #1;
      hold(1'b0, 12);
      chk("t1_nerr", err_n - e0, 0);

      // "4" "2" then word gap
      mark_start();
      send_code(code_of(4));
      hold(1'b0, 3 * DOT);
      send_code(code_of(2));
      hold(1'b0, 10 * DOT);
      chk("t2_ndig", dig_q.size() - d0, 2);
      if (dig_q.size() >= d0 + 2) begin
         chk("t2_d0", dig_q[d0], 4);
         chk("t2_d1", dig_q[d0 + 1], 2);
      end
      chk_word("t2", 16'h0042, 1'b0);
      chk("t2_par_hold", parallel, 16'h0042);

      // five digits overflow, then a fresh word "7"
      mark_start();
      for (int d = 1; d <= 5; d++) begin
         send_code(code_of(d));
         hold(1'b0, 3 * DOT);
      end
      hold(1'b0, 7 * DOT);
      chk("t3_ndig", dig_q.size() - d0, 5);
      chk_word("t3", 16'h2345, 1'b1);
      mark_start();
      send_code(code_of(7));
      hold(1'b0, 10 * DOT);
      chk_word("t3b", 16'h0007, 1'b0);

      // letter A
      mark_start();
      send_code(".-");
      hold(1'b0, 10 * DOT);
`ifdef MORSE_DECODER_HEX_EN
      chk("t4_ndig", dig_q.size() - d0, 1);
      if (dig_q.size() > d0) chk("t4_digit", dig_q[d0], 4'hA);
      chk("t4_nerr", err_n - e0, 0);
      chk_word("t4", 16'h000A, 1'b0);
`else
      chk("t4_ndig", dig_q.size() - d0, 0);
      chk("t4_nerr", err_n - e0, 1);
      chk("t4_nword", par_q.size() - w0, 0);
      chk("t4_par_hold", parallel, 16'h0007);
`endif

      // 6-unit mark, then "3"
      mark_start();
      hold(1'b1, 6 * DOT);
      serial = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_err_early", error, 0);
      @(negedge clk);
      chk("t5_err", error, 1);
      @(posedge clk);
      #1;
      hold(1'b0, 3 * DOT);
      send_code(code_of(3));
      hold(1'b0, 10 * DOT);
      chk("t5_nerr", err_n - e0, 1);
      chk("t5_ndig", dig_q.size() - d0, 1);
      chk_word("t5", 16'h0003, 1'b0);

      // reset in the middle of the dash opening the second digit
      mark_start();
      send_code(code_of(1));
      hold(1'b0, 3 * DOT);
      hold(1'b1, 6);
      rst = 1'b1;
      #1;
      chk("t6_rst_digit", digit, 0);
      chk("t6_rst_par", parallel, 0);
      chk("t6_rst_flags", {digit_valid, word_valid, overflow, error}, 0);
      serial = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      hold(1'b0, 3 * DOT);
      mark_start();
      send_code(code_of(9));
      hold(1'b0, 10 * DOT);
      chk("t6_ndig", dig_q.size() - d0, 1);
      if (dig_q.size() > d0) chk("t6_digit", dig_q[d0], 9);
      chk("t6_nerr", err_n - e0, 0);
      chk_word("t6", 16'h0009, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
